// File: rtl/mult_div_seq.sv
// Multicycle HI/LO sequencer: 32-step radix-2 Booth signed multiply or
// signed restoring divide, with a one-cycle done/hilo_write/div_zero pulse.
module mult_div_seq #(
  parameter int DATA_W = 32,
  parameter int ITER   = 32,
  parameter int CNT_W  = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              op,
  input  logic [DATA_W-1:0] a_in,
  input  logic [DATA_W-1:0] b_in,
  output logic              busy,
  output logic              done,
  output logic              div_zero,
  output logic              hilo_write,
  output logic [DATA_W-1:0] hi_out,
  output logic [DATA_W-1:0] lo_out
);

  typedef enum logic [1:0] {IDLE, MULT, DIV, DONE} state_t;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(ITER - 1);

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W:0]   acc;      // Booth accumulator, or divide remainder in [DATA_W-1:0]
  logic [DATA_W-1:0] qr;       // multiplier / quotient shift register
  logic [DATA_W-1:0] mcand;    // multiplicand, or divisor magnitude
  logic              q_1, sign_q, sign_r;
  logic              accept, take, b_zero, last, iter;

  assign accept = (state == IDLE) || (state == DONE);
  assign take   = accept && start;
  assign b_zero = (b_in == '0);
  assign last   = (cnt == LAST);
  assign iter   = (state == MULT) || (state == DIV);

  // Booth step: add/sub on {q0,q-1}, then arithmetic shift of {acc,qr,q_1}
  logic [DATA_W:0]   m_ext, b_sum, b_acc_nxt;
  logic [DATA_W-1:0] b_q_nxt;
  assign m_ext = {mcand[DATA_W-1], mcand};
  always_comb begin
    b_sum = acc;
    case ({qr[0], q_1})
      2'b01:   b_sum = acc + m_ext;
      2'b10:   b_sum = acc - m_ext;
      default: b_sum = acc;
    endcase
  end
  assign b_acc_nxt = {b_sum[DATA_W], b_sum[DATA_W:1]};
  assign b_q_nxt   = {b_sum[0], qr[DATA_W-1:1]};

  // Restoring step on magnitudes: remainder stays below divisor, so 33 bits suffice
  logic [DATA_W:0]   r_sh, r_diff;
  logic              r_borrow;
  logic [DATA_W-1:0] d_rem_nxt, d_quo_nxt;
  assign r_sh      = {acc[DATA_W-1:0], qr[DATA_W-1]};
  assign r_diff    = r_sh - {1'b0, mcand};
  assign r_borrow  = (r_sh < {1'b0, mcand});
  assign d_rem_nxt = r_borrow ? r_sh[DATA_W-1:0] : r_diff[DATA_W-1:0];
  assign d_quo_nxt = {qr[DATA_W-2:0], ~r_borrow};

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: begin
        if (!start)      state_nxt = IDLE;
        else if (!op)    state_nxt = MULT;
        else if (b_zero) state_nxt = DONE;
        else             state_nxt = DIV;
      end
      MULT, DIV: if (last) state_nxt = DONE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = iter;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0; acc <= '0; qr <= '0; mcand <= '0;
      q_1 <= 1'b0; sign_q <= 1'b0; sign_r <= 1'b0;
      hi_out <= '0; lo_out <= '0;
      done <= 1'b0; div_zero <= 1'b0; hilo_write <= 1'b0;
    end else begin
      done       <= (state_nxt == DONE);
      div_zero   <= take && op && b_zero;
      hilo_write <= iter && last;
      if (take) begin
        cnt <= '0;
        acc <= '0;
        q_1 <= 1'b0;
        if (!op) begin
          qr    <= b_in;
          mcand <= a_in;
        end else begin
          qr     <= a_in[DATA_W-1] ? -a_in : a_in;
          mcand  <= b_in[DATA_W-1] ? -b_in : b_in;
          sign_q <= a_in[DATA_W-1] ^ b_in[DATA_W-1];
          sign_r <= a_in[DATA_W-1];
        end
      end else if (state == MULT) begin
        cnt <= cnt + 1'b1;
        acc <= b_acc_nxt;
        qr  <= b_q_nxt;
        q_1 <= qr[0];
        if (last) begin
          hi_out <= b_acc_nxt[DATA_W-1:0];
          lo_out <= b_q_nxt;
        end
      end else if (state == DIV) begin
        cnt <= cnt + 1'b1;
        acc <= {1'b0, d_rem_nxt};
        qr  <= d_quo_nxt;
        if (last) begin
          hi_out <= sign_r ? -d_rem_nxt : d_rem_nxt;
          lo_out <= sign_q ? -d_quo_nxt : d_quo_nxt;
        end
      end
    end
  end

endmodule

// File: tb/tb_mult_div_seq.sv
// Bench for mult_div_seq: cycle-level reference model with per-cycle compare,
// plus directed vectors with hand-computed HI/LO and latency.
module tb_mult_div_seq;
  localparam int W = 32;

  logic          clk = 1'b0, reset = 1'b1, start = 1'b0, op = 1'b0;
  logic [W-1:0]  a_in = '0, b_in = '0;
  logic          busy, done, div_zero, hilo_write;
  logic [W-1:0]  hi_out, lo_out;
  int            checks = 0, errors = 0;

  mult_div_seq #(.DATA_W(W), .ITER(32), .CNT_W(6)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a_in(a_in), .b_in(b_in),
    .busy(busy), .done(done), .div_zero(div_zero), .hilo_write(hilo_write),
    .hi_out(hi_out), .lo_out(lo_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Signed reference: {hi,lo} = product, or {remainder,quotient} truncated toward zero
  function automatic logic [63:0] ref_op(input logic o, input logic [W-1:0] a, input logic [W-1:0] b);
    longint sa, sb;
    logic [63:0] p, q, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (!o) begin
      p = sa * sb;
      return p;
    end
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  // Model: an accepted op keeps the unit busy for W edges, then one done cycle
  int          busy_left = 0;
  bit          armed = 0;
  logic        e_busy = 0, e_done = 0, e_dz = 0, e_hw = 0;
  logic [W-1:0] e_hi = '0, e_lo = '0;
  logic [63:0] pend = '0;

  always @(posedge clk) begin
    armed  = 1;
    e_done = 0; e_dz = 0; e_hw = 0;
    if (reset) begin
      busy_left = 0; e_hi = '0; e_lo = '0;
    end else if (busy_left > 0) begin
      busy_left--;
      if (busy_left == 0) begin
        e_done = 1; e_hw = 1; {e_hi, e_lo} = pend;
      end
    end else if (start) begin
      if (op && b_in == '0) begin
        e_done = 1; e_dz = 1;
      end else begin
        busy_left = W;
        pend = ref_op(op, a_in, b_in);
      end
    end
    e_busy = (busy_left > 0);
  end

  always @(negedge clk) begin
    if (armed) begin
      chk("cyc_busy", busy, e_busy);
      chk("cyc_done", done, e_done);
      chk("cyc_div_zero", div_zero, e_dz);
      chk("cyc_hilo_write", hilo_write, e_hw);
      chk("cyc_hi", hi_out, e_hi);
      chk("cyc_lo", lo_out, e_lo);
    end
  end

  task automatic launch(input logic o, input logic [W-1:0] a, input logic [W-1:0] b);
    @(posedge clk); #1;
    start = 1; op = o; a_in = a; b_in = b;
    @(posedge clk); #1;
    start = 0; op = 1'($urandom); a_in = $urandom; b_in = $urandom;
  endtask

  // Count negedges until done; exits at the negedge of the done cycle
  task automatic wait_done(input int exp_n, input string name);
    int n = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (done) begin
        n = i;
        break;
      end
    end
    chk({name, "_latency"}, n, exp_n);
  endtask

  task automatic run(input logic o, input logic [W-1:0] a, input logic [W-1:0] b, input int exp_n,
                     input logic [W-1:0] exp_hi, input logic [W-1:0] exp_lo,
                     input logic exp_hw, input logic exp_dz, input string name);
    launch(o, a, b);
    wait_done(exp_n, name);
    chk({name, "_hi"}, hi_out, exp_hi);
    chk({name, "_lo"}, lo_out, exp_lo);
    chk({name, "_hilo_write"}, hilo_write, exp_hw);
    chk({name, "_div_zero"}, div_zero, exp_dz);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_hi", hi_out, 0);
    chk("rst_lo", lo_out, 0);
    @(posedge clk); #1 reset = 0;

    run(0, 7, 6, 33, 32'h0, 32'd42, 1, 0, "mul_7x6");
    run(0, 32'hFFFFFFFD, 5, 33, 32'hFFFFFFFF, 32'hFFFFFFF1, 1, 0, "mul_neg3x5");
    run(0, 32'h80000000, 32'h80000000, 33, 32'h40000000, 32'h0, 1, 0, "mul_min");
    run(1, 32'hFFFFFFF9, 2, 33, 32'hFFFFFFFF, 32'hFFFFFFFD, 1, 0, "div_neg7_2");
    run(1, 32'h80000000, 32'hFFFFFFFF, 33, 32'h0, 32'h80000000, 1, 0, "div_wrap");
    run(1, 59, 6, 33, 32'd5, 32'd9, 1, 0, "div_59_6");
    run(1, 100, 0, 1, 32'd5, 32'd9, 0, 1, "div_by_zero");

    // start held through DONE: second op accepted with no IDLE cycle
    @(posedge clk); #1;
    start = 1; op = 0; a_in = 3; b_in = 4;
    @(posedge clk); #1;
    op = 1; a_in = 10; b_in = 32'hFFFFFFFE;
    wait_done(33, "b2b_first");
    chk("b2b_first_lo", lo_out, 32'd12);
    chk("b2b_first_hi", hi_out, 32'd0);
    @(posedge clk); #1 start = 0;
    @(negedge clk);
    chk("b2b_busy_no_idle", busy, 1);
    wait_done(32, "b2b_second");
    chk("b2b_second_lo", lo_out, 32'hFFFFFFFB);
    chk("b2b_second_hi", hi_out, 32'd0);

    // start pulse and operand churn during a MULT are ignored
    launch(0, 32'h00012345, 32'h00000100);
    repeat (5) @(posedge clk);
    #1 start = 1; op = 1; b_in = 0; a_in = 32'hDEADBEEF;
    @(posedge clk); #1 start = 0;
    wait_done(27, "mid_pulse");
    chk("mid_pulse_lo", lo_out, 32'h01234500);
    chk("mid_pulse_hi", hi_out, 32'h0);
    chk("mid_pulse_div_zero", div_zero, 0);

    // reset sampled at iteration 10 of a DIV
    launch(1, 1000, 7);
    repeat (9) @(posedge clk);
    #1 reset = 1;
    @(posedge clk); #1 reset = 0;
    @(negedge clk);
    chk("abort_busy", busy, 0);
    chk("abort_hi", hi_out, 0);
    chk("abort_lo", lo_out, 0);
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      chk("abort_no_done", done, 0);
    end
    run(0, 32'hFFFFFFFF, 32'hFFFFFFFF, 33, 32'h0, 32'h1, 1, 0, "mul_after_abort");

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
